// File: rtl/svm_pkg.sv
// Shared definitions for the serial-MAC linear SVM scorer: FSM state codes,
// a constant-evaluable clog2 and the output saturation helper.
package svm_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MAC    = 2'd1;
  localparam logic [1:0] ST_ARGMAX = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  // Clamp a sign-extended accumulator into the range of an out_w-bit signed value.
  // The caller truncates the result to out_w bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (acc > hi) begin
      return hi;
    end
    if (acc < lo) begin
      return lo;
    end
    return acc;
  endfunction

endpackage

// File: rtl/svm_mac_lane.sv
// One multiply-accumulate lane: loads the sign-extended intercept, then adds
// unsigned feature times signed weight once per enabled cycle.
module svm_mac_lane
  import svm_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int W_W   = 8,
  parameter int B_W   = 12,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [B_W-1:0]   bias,
  input  logic [IN_W-1:0]         x,
  input  logic signed [W_W-1:0]   w,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] w_x_ext;
  logic signed [ACC_W-1:0] w_w_ext;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] r_acc;

  // The feature is unsigned: a zero MSB keeps it non-negative before widening.
  assign w_x_ext = ACC_W'($signed({1'b0, x}));
  assign w_w_ext = ACC_W'(w);
  // ACC_W is sized so the product and running sum never wrap.
  assign w_prod  = w_x_ext * w_w_ext;

  // Accumulator: bias load has priority over accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (load) begin
      r_acc <= ACC_W'(bias);
    end else if (en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/svm_serial_mac_classifier.sv
// Time-multiplexed linear SVM scorer: one feature per cycle, one MAC lane per
// class, serial argmax, saturated registered scores with valid/ready handshakes.
module svm_serial_mac_classifier
  import svm_pkg::*;
#(
  parameter int NUM_FEAT  = 11,
  parameter int IN_W      = 4,
  parameter int W_W       = 8,
  parameter int B_W       = 12,
  parameter int NUM_CLASS = 1,
  parameter int OUT_W     = 13,
  // Feature 0 is the least-significant byte (4), feature 10 the most (28).
  parameter logic [NUM_CLASS*NUM_FEAT*W_W-1:0] WEIGHTS =
    {8'h1C, 8'h08, 8'h0C, 8'hB4, 8'hFC, 8'h09, 8'h00, 8'h39, 8'h00, 8'hE0, 8'h04},
  parameter logic [NUM_CLASS*B_W-1:0] INTERCEPTS = 12'd1357,
  localparam int CLS_W = (NUM_CLASS > 1) ? clog2(NUM_CLASS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FEAT*IN_W-1:0]     inp,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CLASS*OUT_W-1:0]   out,
  output logic [CLS_W-1:0]             out_class
);

  localparam int ACC_A    = B_W + 1;
  localparam int ACC_B    = W_W + IN_W + 1 + clog2(NUM_FEAT) + 1;
  localparam int ACC_W    = (ACC_A > ACC_B) ? ACC_A : ACC_B;
  // Counter runs 0..NUM_FEAT; the final value is a drain cycle with no MAC.
  localparam int CNT_W    = (clog2(NUM_FEAT + 1) > 0) ? clog2(NUM_FEAT + 1) : 1;
  // Power-of-two padded tables so every counter/index value selects a real entry.
  localparam int FEAT_PAD = 1 << CNT_W;
  localparam int CLS_PAD  = 1 << CLS_W;

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_next;
  logic [CNT_W-1:0]            r_feat_cnt;
  logic [NUM_FEAT*IN_W-1:0]    r_inp;
  logic [CLS_W-1:0]            r_arg_idx;
  logic [CLS_W-1:0]            r_best_idx;
  logic [CLS_W-1:0]            w_best_idx_next;
  logic signed [ACC_W-1:0]     r_best_val;
  logic signed [ACC_W-1:0]     w_best_val_next;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic [NUM_CLASS*OUT_W-1:0]  r_out;
  logic [NUM_CLASS*OUT_W-1:0]  w_out_sat;
  logic [CLS_W-1:0]            r_out_class;

  logic [IN_W-1:0]             w_feat [FEAT_PAD];
  logic signed [W_W-1:0]       w_wt   [NUM_CLASS][FEAT_PAD];
  logic signed [ACC_W-1:0]     w_acc  [CLS_PAD];
  logic [IN_W-1:0]             w_x;

  logic                        w_accept;
  logic                        w_en;
  logic                        w_mac_last;
  logic                        w_arg_last;
  logic                        w_enter_done;
  logic                        w_release;
  logic                        w_take;

  genvar gi;
  genvar gj;

  // Feature mux over the latched vector; padding slots read as zero.
  for (gi = 0; gi < FEAT_PAD; gi++) begin : g_feat
    if (gi < NUM_FEAT) begin : g_real
      assign w_feat[gi] = r_inp[gi*IN_W +: IN_W];
    end else begin : g_pad
      assign w_feat[gi] = '0;
    end
  end

  assign w_x = w_feat[r_feat_cnt];

  // Per-class weight tables, MAC lanes and saturated score slices.
  for (gi = 0; gi < NUM_CLASS; gi++) begin : g_cls
    for (gj = 0; gj < FEAT_PAD; gj++) begin : g_wt
      if (gj < NUM_FEAT) begin : g_real
        assign w_wt[gi][gj] = WEIGHTS[(gi*NUM_FEAT + gj)*W_W +: W_W];
      end else begin : g_pad
        assign w_wt[gi][gj] = '0;
      end
    end

    svm_mac_lane #(
      .IN_W  (IN_W),
      .W_W   (W_W),
      .B_W   (B_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_accept),
      .en    (w_en),
      .bias  (INTERCEPTS[gi*B_W +: B_W]),
      .x     (w_x),
      .w     (w_wt[gi][r_feat_cnt]),
      .acc   (w_acc[gi])
    );

    assign w_out_sat[gi*OUT_W +: OUT_W] = OUT_W'(sat(64'(w_acc[gi]), OUT_W));
  end

  for (gi = NUM_CLASS; gi < CLS_PAD; gi++) begin : g_acc_pad
    assign w_acc[gi] = '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; argmax is bypassed for a single score.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)   w_state_next = ST_MAC;
      ST_MAC:    if (w_mac_last) w_state_next = (NUM_CLASS > 1) ? ST_ARGMAX : ST_DONE;
      ST_ARGMAX: if (w_arg_last) w_state_next = ST_DONE;
      ST_DONE:   if (out_ready)  w_state_next = ST_IDLE;
      default:                   w_state_next = ST_IDLE;
    endcase
  end

  // FSM-decoded control strobes.
  always_comb begin
    w_accept     = 1'b0;
    w_en         = 1'b0;
    w_mac_last   = 1'b0;
    w_arg_last   = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = in_valid && r_in_ready;
      end
      ST_MAC: begin
        w_en       = (r_feat_cnt != CNT_W'(NUM_FEAT));
        w_mac_last = (r_feat_cnt == CNT_W'(NUM_FEAT));
      end
      ST_ARGMAX: begin
        w_arg_last = (r_arg_idx == CLS_W'(NUM_CLASS - 1));
      end
      ST_DONE: begin
        w_release = out_ready;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
    w_enter_done = (w_state_next == ST_DONE) && (r_state != ST_DONE);
  end

  // Argmax step: strictly greater replaces the best, so ties keep the lowest index.
  always_comb begin
    w_take          = (w_acc[r_arg_idx] > r_best_val);
    w_best_idx_next = w_take ? r_arg_idx : r_best_idx;
    w_best_val_next = w_take ? w_acc[r_arg_idx] : r_best_val;
  end

  // Input latch, feature counter and argmax tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inp      <= '0;
      r_feat_cnt <= '0;
      r_arg_idx  <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
    end else begin
      if (w_accept) begin
        r_inp      <= inp;
        r_feat_cnt <= '0;
      end else if (w_en) begin
        r_feat_cnt <= r_feat_cnt + CNT_W'(1);
      end
      if (w_mac_last) begin
        r_arg_idx  <= CLS_W'(1);
        r_best_idx <= '0;
        r_best_val <= w_acc[0];
      end else if (r_state == ST_ARGMAX) begin
        r_arg_idx  <= r_arg_idx + CLS_W'(1);
        r_best_idx <= w_best_idx_next;
        r_best_val <= w_best_val_next;
      end
    end
  end

  // in_ready is registered so it stays low while reset is held and rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_next == ST_IDLE);
    end
  end

  // Result registers: capture on DONE entry, hold until the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_class <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_enter_done) begin
        r_out       <= w_out_sat;
        r_out_class <= (NUM_CLASS > 1) ? w_best_idx_next : '0;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_class = r_out_class;

endmodule

// File: tb/tb_svm_serial_mac_classifier.sv
// Directed bench: default regressor, two saturating variants sharing its
// stimulus, and a 3-class / 2-feature classifier.
module tb_svm_serial_mac_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               out_ready;
  logic               in_valid_d;
  logic               in_valid_c;
  logic [43:0]        inp_d;
  logic [7:0]         inp_c;
  logic               in_ready_d, in_ready_s, in_ready_n, in_ready_c;
  logic               out_valid_d, out_valid_s, out_valid_n, out_valid_c;
  logic signed [12:0] out_d;
  logic signed [9:0]  out_s;
  logic signed [9:0]  out_n;
  logic [38:0]        out_c;
  logic [0:0]         cls_d, cls_s, cls_n;
  logic [1:0]         cls_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [43:0] vec_tab [3] = '{44'hFFFFFFFFFFF, 44'h000F0000000, 44'h0000000F000};
  int          exp_tab [3] = '{1447, 217, 2212};

  svm_serial_mac_classifier u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_d), .inp(inp_d),
    .out_valid(out_valid_d), .out_ready(out_ready), .out(out_d), .out_class(cls_d)
  );

  svm_serial_mac_classifier #(.OUT_W(10)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_s), .inp(inp_d),
    .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s), .out_class(cls_s)
  );

  svm_serial_mac_classifier #(.OUT_W(10), .INTERCEPTS(12'hC18)) u_neg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_n), .inp(inp_d),
    .out_valid(out_valid_n), .out_ready(out_ready), .out(out_n), .out_class(cls_n)
  );

  svm_serial_mac_classifier #(
    .NUM_FEAT(2), .NUM_CLASS(3),
    .WEIGHTS(48'h000101000001), .INTERCEPTS(36'd0)
  ) u_cls (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .inp(inp_c),
    .out_valid(out_valid_c), .out_ready(out_ready), .out(out_c), .out_class(cls_c)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one vector and return the number of edges from accept to out_valid (0 = timeout).
  task automatic send(input bit to_cls, input logic [43:0] vec, output int lat);
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      if (to_cls ? in_ready_c : in_ready_d) break;
      @(posedge clk); #1;
    end
    if (to_cls) begin
      inp_c      = vec[7:0];
      in_valid_c = 1'b1;
    end else begin
      inp_d      = vec;
      in_valid_d = 1'b1;
    end
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    in_valid_d = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (to_cls ? out_valid_c : out_valid_d) begin
        lat = k;
        break;
      end
    end
  endtask

  // Accept the result for one edge and confirm valid drops and ready returns.
  task automatic take(input bit to_cls, input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, to_cls ? out_valid_c : out_valid_d, 0);
    chk({tag, "_in_ready_back"}, to_cls ? in_ready_c : in_ready_d, 1);
  endtask

  initial begin
    int lat;
    int seen;

    rst_n      = 1'b0;
    out_ready  = 1'b0;
    in_valid_d = 1'b0;
    in_valid_c = 1'b0;
    inp_d      = '0;
    inp_c      = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_d, 0);
    chk("rst_in_ready_cls", in_ready_c, 0);
    chk("rst_out_valid", out_valid_d, 0);
    chk("rst_out", out_d, 0);
    chk("rst_out_class", cls_d, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready_d, 1);
    chk("ready_after_rst_sat", in_ready_s & in_ready_n, 1);

    // Zero features: intercept only, plus both saturation variants.
    send(1'b0, 44'd0, lat);
    $display("txn zero: latency=%0d out=%0d sat_pos=%0d sat_neg=%0d", lat, out_d, out_s, out_n);
    chk("zero_latency", lat, 12);
    chk("zero_out", out_d, 1357);
    chk("zero_class", cls_d, 0);
    chk("sat_pos_valid", out_valid_s & out_valid_n, 1);
    chk("sat_pos_out", out_s, 511);
    chk("sat_neg_out", out_n, -512);
    take(1'b0, "zero");

    // Directed feature patterns.
    for (int i = 0; i < 3; i++) begin
      send(1'b0, vec_tab[i], lat);
      $display("txn pattern%0d: inp=%h latency=%0d out=%0d", i, vec_tab[i], lat, out_d);
      chk($sformatf("pat%0d_latency", i), lat, 12);
      chk($sformatf("pat%0d_out", i), out_d, exp_tab[i]);
      take(1'b0, $sformatf("pat%0d", i));
    end

    // Back-pressure: hold the result while a new vector is offered and must be ignored.
    send(1'b0, 44'h0000000F000, lat);
    $display("txn backpressure: latency=%0d out=%0d", lat, out_d);
    chk("bp_latency", lat, 12);
    inp_d      = 44'hFFFFFFFFFFF;
    in_valid_d = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", k), out_valid_d, 1);
      chk($sformatf("bp_out_%0d", k), out_d, 2212);
      chk($sformatf("bp_ready_%0d", k), in_ready_d, 0);
    end
    in_valid_d = 1'b0;
    take(1'b0, "bp");
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid_d) seen++;
    end
    chk("bp_ignored_vector", seen, 0);
    chk("bp_out_held", out_d, 2212);

    // Reset in the middle of accumulation aborts the result.
    inp_d      = 44'hFFFFFFFFFFF;
    in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    $display("txn midreset: out_valid=%0d out=%0d in_ready=%0d", out_valid_d, out_d, in_ready_d);
    chk("midrst_out_valid", out_valid_d, 0);
    chk("midrst_out", out_d, 0);
    chk("midrst_in_ready", in_ready_d, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_back", in_ready_d, 1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid_d) seen++;
    end
    chk("midrst_no_result", seen, 0);
    send(1'b0, 44'd0, lat);
    $display("txn after_reset: latency=%0d out=%0d", lat, out_d);
    chk("after_rst_latency", lat, 12);
    chk("after_rst_out", out_d, 1357);
    take(1'b0, "after_rst");

    // Three-class argmax: tie resolves to lowest index, then a clear winner.
    send(1'b1, 44'h55, lat);
    $display("txn cls_tie: latency=%0d class=%0d scores=%0d,%0d,%0d", lat, cls_c,
             $signed(out_c[12:0]), $signed(out_c[25:13]), $signed(out_c[38:26]));
    chk("tie_latency", lat, 5);
    chk("tie_class", cls_c, 0);
    chk("tie_score0", $signed(out_c[12:0]), 5);
    chk("tie_score1", $signed(out_c[25:13]), 5);
    chk("tie_score2", $signed(out_c[38:26]), 5);
    take(1'b1, "tie");

    send(1'b1, 44'h95, lat);
    $display("txn cls_win: latency=%0d class=%0d scores=%0d,%0d,%0d", lat, cls_c,
             $signed(out_c[12:0]), $signed(out_c[25:13]), $signed(out_c[38:26]));
    chk("win_latency", lat, 5);
    chk("win_class", cls_c, 1);
    chk("win_score1", $signed(out_c[25:13]), 9);
    chk("win_score2", $signed(out_c[38:26]), 5);
    take(1'b1, "win");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
